// File: rtl/mips_exec_pipe.sv
// Three-stage MIPS integer execute core (ID/read, ALU, writeback) with internal register file.
// Build option MIPS_EXEC_FWD_EN: forward the ALU output to operand read instead of stalling.
module mips_exec_pipe #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_valid,
  input  logic [31:0]       inst,
  output logic              inst_ready,
  output logic [DATA_W-1:0] aluresult,
  output logic [DATA_W-1:0] writeonmem,
  output logic              mem_we,
  output logic              result_valid,
  output logic              illegal
);
  localparam int RW = $clog2(NREGS);
`ifdef MIPS_EXEC_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef enum logic [3:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLL, OP_LUI, OP_SW, OP_BAD} op_e;

  logic [DATA_W-1:0] regs [NREGS];
  logic [4:0]        rs, rt;
  logic [DATA_W-1:0] simm, zimm, luimm;
  op_e               dec_op;
  logic              dec_use_imm, dec_rs_used, dec_rt_used, dec_wen;
  logic [DATA_W-1:0] dec_imm;
  logic [4:0]        dec_dst;

  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign simm  = {{(DATA_W-16){inst[15]}}, inst[15:0]};
  assign zimm  = {{(DATA_W-16){1'b0}}, inst[15:0]};
  assign luimm = DATA_W'({inst[15:0], 16'h0000});

  always_comb begin
    dec_op      = OP_BAD;
    dec_use_imm = 1'b0;
    dec_imm     = '0;
    dec_dst     = inst[15:11];
    dec_rs_used = 1'b0;
    dec_rt_used = 1'b0;
    case (inst[31:26])
      6'h00: begin
        dec_rs_used = 1'b1;
        dec_rt_used = 1'b1;
        case (inst[5:0])
          6'h20: dec_op = OP_ADD;
          6'h22: dec_op = OP_SUB;
          6'h24: dec_op = OP_AND;
          6'h25: dec_op = OP_OR;
          6'h2A: dec_op = OP_SLT;
          6'h00: begin dec_op = OP_SLL; dec_rs_used = 1'b0; end
          default: begin dec_rs_used = 1'b0; dec_rt_used = 1'b0; end
        endcase
      end
      6'h08: begin dec_op = OP_ADD; dec_use_imm = 1'b1; dec_imm = simm;  dec_dst = rt; dec_rs_used = 1'b1; end
      6'h0C: begin dec_op = OP_AND; dec_use_imm = 1'b1; dec_imm = zimm;  dec_dst = rt; dec_rs_used = 1'b1; end
      6'h0D: begin dec_op = OP_OR;  dec_use_imm = 1'b1; dec_imm = zimm;  dec_dst = rt; dec_rs_used = 1'b1; end
      6'h0F: begin dec_op = OP_LUI; dec_use_imm = 1'b1; dec_imm = luimm; dec_dst = rt; end
      6'h2B: begin
        dec_op = OP_SW; dec_use_imm = 1'b1; dec_imm = simm;
        dec_rs_used = 1'b1; dec_rt_used = 1'b1;
      end
      default: ;
    endcase
  end

  // Only writes that will actually land in the file count for hazards and forwarding.
  assign dec_wen = (dec_op != OP_BAD) && (dec_op != OP_SW) && (dec_dst != 5'd0) && (32'(dec_dst) < NREGS);

  logic              idex_valid, idex_wen;
  op_e               idex_op;
  logic [DATA_W-1:0] idex_a, idex_b, idex_sd;
  logic [4:0]        idex_shamt, idex_dst;
  logic              wb_wen;
  logic [4:0]        wb_dst;
  logic [DATA_W-1:0] alu_out, rf_rs, rf_rt, rs_val, rt_val;
  logic              hazard, transfer;

  assign rf_rs = (32'(rs) < NREGS) ? regs[rs[RW-1:0]] : '0;
  assign rf_rt = (32'(rt) < NREGS) ? regs[rt[RW-1:0]] : '0;

  // Priority: ALU forward, then write-through of the retiring result, then the file.
  assign rs_val = (rs == 5'd0) ? '0 :
                  (FWD && idex_wen && idex_dst == rs) ? alu_out :
                  (wb_wen && wb_dst == rs) ? aluresult : rf_rs;
  assign rt_val = (rt == 5'd0) ? '0 :
                  (FWD && idex_wen && idex_dst == rt) ? alu_out :
                  (wb_wen && wb_dst == rt) ? aluresult : rf_rt;

  assign hazard = !FWD && inst_valid && idex_wen &&
                  ((dec_rs_used && rs == idex_dst) || (dec_rt_used && rt == idex_dst));
  assign inst_ready = reset || !hazard;
  assign transfer   = inst_valid && inst_ready && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_valid <= 1'b0;
      idex_wen   <= 1'b0;
    end else begin
      idex_valid <= transfer;
      idex_wen   <= transfer && dec_wen;
      idex_op    <= dec_op;
      idex_a     <= rs_val;
      idex_b     <= dec_use_imm ? dec_imm : rt_val;
      idex_sd    <= rt_val;
      idex_shamt <= inst[10:6];
      idex_dst   <= dec_dst;
    end
  end

  always_comb begin
    alu_out = '0;
    case (idex_op)
      OP_ADD, OP_SW: alu_out = idex_a + idex_b;
      OP_SUB:        alu_out = idex_a - idex_b;
      OP_AND:        alu_out = idex_a & idex_b;
      OP_OR:         alu_out = idex_a | idex_b;
      OP_SLT:        alu_out[0] = $signed(idex_a) < $signed(idex_b);
      OP_SLL:        alu_out = idex_b << idex_shamt;
      OP_LUI:        alu_out = idex_b;
      default:       alu_out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aluresult    <= '0;
      writeonmem   <= '0;
      mem_we       <= 1'b0;
      result_valid <= 1'b0;
      illegal      <= 1'b0;
      wb_wen       <= 1'b0;
      wb_dst       <= '0;
    end else begin
      aluresult    <= (idex_valid && idex_op != OP_BAD) ? alu_out : '0;
      writeonmem   <= (idex_valid && idex_op == OP_SW) ? idex_sd : '0;
      mem_we       <= idex_valid && idex_op == OP_SW;
      result_valid <= idex_valid && idex_op != OP_SW && idex_op != OP_BAD;
      illegal      <= idex_valid && idex_op == OP_BAD;
      wb_wen       <= idex_wen;
      wb_dst       <= idex_dst;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_wen) begin
      regs[wb_dst[RW-1:0]] <= aluresult;
    end
  end
endmodule

// File: tb/tb_mips_exec_pipe.sv
// Scoreboard bench for mips_exec_pipe: an in-order ISA model predicts each cycle's result-stage
// outputs and inst_ready; runs a 32-bit/32-reg instance, then a 64-bit/8-reg instance.
module tb_mips_exec_pipe;
  typedef logic [130:0] obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        iv_a, iv_b, rdy_a, rdy_b;
  logic [31:0] inst_a, inst_b;
  logic [31:0] alu_a, wm_a;
  logic [63:0] alu_b, wm_b;
  logic        we_a, rv_a, ill_a, we_b, rv_b, ill_b;

  always #5 clk = ~clk;

  mips_exec_pipe dut_a (
    .clk(clk), .reset(reset), .inst_valid(iv_a), .inst(inst_a), .inst_ready(rdy_a),
    .aluresult(alu_a), .writeonmem(wm_a), .mem_we(we_a), .result_valid(rv_a), .illegal(ill_a));

  mips_exec_pipe #(.DATA_W(64), .NREGS(8)) dut_b (
    .clk(clk), .reset(reset), .inst_valid(iv_b), .inst(inst_b), .inst_ready(rdy_b),
    .aluresult(alu_b), .writeonmem(wm_b), .mem_we(we_b), .result_valid(rv_b), .illegal(ill_b));

  obs_t        q[$];
  int          checks = 0, failures = 0;
  int          sel, cur_w, cur_n;
  logic [63:0] mask;
  logic [63:0] mreg [32];
  bit          m_ex_wen;
  logic [4:0]  m_ex_dst;
  string       phase;

  task automatic check_eq(input string tag, input obs_t obs, input obs_t exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic obs_t observed();
    if (sel == 0) return {32'h0, alu_a, 32'h0, wm_a, we_a, rv_a, ill_a};
    return {alu_b, wm_b, we_b, rv_b, ill_b};
  endfunction

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [63:0] rdm(input logic [4:0] idx);
    if (idx == 5'd0 || int'(idx) >= cur_n) return 64'h0;
    return mreg[idx];
  endfunction

  function automatic bit model_ready(input logic [31:0] i);
    bit rsu = 1'b0, rtu = 1'b0, stall;
    case (i[31:26])
      6'h00: begin
        if (i[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin rsu = 1'b1; rtu = 1'b1; end
        else if (i[5:0] == 6'h00) rtu = 1'b1;
      end
      6'h08, 6'h0C, 6'h0D: rsu = 1'b1;
      6'h2B: begin rsu = 1'b1; rtu = 1'b1; end
      default: ;
    endcase
    stall = m_ex_wen && ((rsu && i[25:21] == m_ex_dst) || (rtu && i[20:16] == m_ex_dst));
`ifdef MIPS_EXEC_FWD_EN
    stall = 1'b0;
`endif
    return !stall;
  endfunction

  task automatic model_exec(input logic [31:0] i, output obs_t e);
    logic [63:0] a, b, simm, zimm, res, wm, sa, sb;
    logic [4:0]  dst;
    bit          wen, we, ill;
    a = rdm(i[25:21]);
    b = rdm(i[20:16]);
    simm = {{48{i[15]}}, i[15:0]} & mask;
    zimm = {48'h0, i[15:0]};
    res = 64'h0; wm = 64'h0; dst = i[15:11]; wen = 1'b1; we = 1'b0; ill = 1'b0;
    case (i[31:26])
      6'h00: case (i[5:0])
        6'h20: res = a + b;
        6'h22: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h2A: begin
          sa = (cur_w == 32) ? {{32{a[31]}}, a[31:0]} : a;
          sb = (cur_w == 32) ? {{32{b[31]}}, b[31:0]} : b;
          res = ($signed(sa) < $signed(sb)) ? 64'd1 : 64'd0;
        end
        6'h00: res = b << i[10:6];
        default: ill = 1'b1;
      endcase
      6'h08: begin res = a + simm; dst = i[20:16]; end
      6'h0C: begin res = a & zimm; dst = i[20:16]; end
      6'h0D: begin res = a | zimm; dst = i[20:16]; end
      6'h0F: begin res = {32'h0, i[15:0], 16'h0}; dst = i[20:16]; end
      6'h2B: begin res = a + simm; wm = b; we = 1'b1; wen = 1'b0; end
      default: ill = 1'b1;
    endcase
    res = res & mask;
    if (ill) begin res = 64'h0; wen = 1'b0; end
    wen = wen && dst != 5'd0 && int'(dst) < cur_n;
    if (wen) mreg[dst] = res;
    m_ex_wen = wen;
    m_ex_dst = dst;
    e = {res, wm, we, !ill && !we, ill};
  endtask

  task automatic drive(input bit v, input logic [31:0] i);
    if (sel == 0) begin iv_a = v; inst_a = i; end
    else begin iv_b = v; inst_b = i; end
  endtask

  task automatic cycle_step(input bit v, input logic [31:0] i, output bit acc);
    obs_t e;
    bit   r;
    @(negedge clk);
    if (q.size() >= 2) begin
      e = q.pop_front();
      check_eq({phase, "/result"}, observed(), e);
    end
    drive(v, i);
    #1;
    r = v ? model_ready(i) : 1'b1;
    check_eq({phase, "/inst_ready"}, obs_t'(sel == 0 ? rdy_a : rdy_b), obs_t'(r));
    acc = v && r;
    if (acc) model_exec(i, e);
    else begin e = '0; m_ex_wen = 1'b0; end
    q.push_back(e);
  endtask

  task automatic run(input logic [31:0] i);
    bit acc = 1'b0;
    for (int n = 0; n < 4 && !acc; n++) cycle_step(1'b1, i, acc);
    check_eq({phase, "/accepted"}, obs_t'(acc), obs_t'(1));
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) cycle_step(1'b0, 32'h0, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 32'h0);
    q.delete();
    foreach (mreg[k]) mreg[k] = 64'h0;
    m_ex_wen = 1'b0;
    @(negedge clk);
    check_eq({phase, "/reset_outputs"}, observed(), '0);
    check_eq({phase, "/reset_ready"}, obs_t'(sel == 0 ? rdy_a : rdy_b), obs_t'(1));
    reset = 1'b0;
    q.push_back('0);
    q.push_back('0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int          k, ra, rb, rd;
    logic [31:0] ri;
    reset = 1'b1; iv_a = 1'b0; iv_b = 1'b0; inst_a = 32'h0; inst_b = 32'h0;
    sel = 0; cur_w = 32; cur_n = 32; mask = 64'h0000_0000_FFFF_FFFF; m_ex_wen = 1'b0; m_ex_dst = 5'd0;
    phase = "reset";
    do_reset();

    phase = "raw_addi_add"; run(32'h20020005); run(32'h00421820);
    phase = "ori_sw";       run(32'h340100FF); run(32'hAC010004);
    phase = "addi_slt";     run(32'h2004FFFF); run(32'h0080282A);
    phase = "reg0";         run(32'h20000007); run(32'h00003020);
    phase = "illegal";      run(32'hFC000000); run(32'h00000021); idle(1);
    phase = "alu_ops";
    run(rtype(1, 2, 7, 0, 'h20));  // 0xFF + 5, regs untouched by illegal ops
    run(rtype(0, 2, 8, 0, 'h22));
    run(rtype(1, 4, 9, 0, 'h24));
    run(rtype(2, 1, 10, 0, 'h25));
    run(rtype(0, 2, 11, 4, 'h00));
    run(itype('h0F, 0, 12, 'h8001));
    run(itype('h0C, 4, 13, 'h0F0F));
    run(rtype(2, 1, 14, 0, 'h2A));
    run(rtype(1, 4, 15, 0, 'h2A));
    run(rtype(4, 4, 16, 0, 'h20));
    run(rtype(11, 16, 17, 0, 'h20));
    idle(2);

    phase = "random";
    for (int n = 0; n < 40; n++) begin
      k  = $urandom_range(0, 10);
      ra = $urandom_range(0, 7);
      rb = $urandom_range(0, 7);
      rd = $urandom_range(0, 7);
      case (k)
        0: ri = rtype(ra, rb, rd, 0, 'h20);
        1: ri = rtype(ra, rb, rd, 0, 'h22);
        2: ri = rtype(ra, rb, rd, 0, 'h24);
        3: ri = rtype(ra, rb, rd, 0, 'h25);
        4: ri = rtype(ra, rb, rd, 0, 'h2A);
        5: ri = rtype(0, rb, rd, $urandom_range(0, 31), 'h00);
        6: ri = itype('h08, ra, rd, $urandom_range(0, 65535));
        7: ri = itype('h0C, ra, rd, $urandom_range(0, 65535));
        8: ri = itype('h0D, ra, rd, $urandom_range(0, 65535));
        9: ri = itype('h2B, ra, rb, $urandom_range(0, 65535));
        default: ri = itype('h0F, 0, rd, $urandom_range(0, 65535));
      endcase
      run(ri);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);

    phase = "reset_in_flight";
    run(itype('h08, 0, 7, 3));
    run(itype('h08, 0, 8, 4));
    do_reset();
    run(rtype(7, 8, 9, 0, 'h20));
    idle(2);

    sel = 1; cur_w = 64; cur_n = 8; mask = 64'hFFFF_FFFF_FFFF_FFFF;
    phase = "w64";
    do_reset();
    run(32'h2004FFFF);
    run(32'h20090005);
    run(32'h01201820);
    run(32'h0080302A);
    run(rtype(4, 4, 5, 0, 'h20));
    run(itype('h2B, 4, 4, 8));
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
